sequence_player: RTL
====================

Name: sequence_player

Overview:
Playback engine for the Simon game. It reads the stored note sequence out of the sequence store, entry 0 first. It drives the oscillator's note select and a gate, plus one-hot LEDs, for a fixed note time. A fixed silent gap follows each note. This block is the reader side of the sequence store; the button/push logic is the writer side. It reports BUSY during playback and pulses DONE when the sequence completes.

Parameters:
DEPTH, 16, number of entries in the sequence store
ADDR_W, clog2(DEPTH) = 4, store address width
NOTE_CYCLES, 25_000_000, clock cycles each note sounds (must be >= 1)
GAP_CYCLES, 5_000_000, clock cycles of silence after each note (must be >= 1)
CNT_W, clog2(max(NOTE_CYCLES,GAP_CYCLES)), width of the duration counter

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin playback; honoured only in IDLE
ABORT  in  1  stop playback immediately; honoured in any state
LENGTH  in  ADDR_W+1  number of entries to play, 0..DEPTH; values above DEPTH clamp to DEPTH
RD_EN  out  1  store read strobe
RD_ADDR  out  ADDR_W  store read address
RD_DATA  in  2  store read data; valid the cycle after RD_EN=1 (registered-read store)
NOTE_SEL  out  2  note index to the oscillator
NOTE_EN  out  1  oscillator/audio gate
LED  out  4  one-hot of NOTE_SEL while NOTE_EN=1, else 0
BUSY  out  1  high from the first ISSUE cycle through the last GAP cycle
DONE  out  1  one-cycle pulse on normal completion

Behaviour:
- All outputs are registered.
- On RST_N=0 (async): state IDLE; RD_EN, RD_ADDR, NOTE_SEL, NOTE_EN, LED, BUSY and DONE are all 0; index, length and counter are 0.
- FSM states: IDLE, ISSUE, WAIT, PLAY, GAP.
- IDLE, START=1, clamped LENGTH != 0: latch len_q = min(LENGTH, DEPTH), set idx = 0, go to ISSUE.
- IDLE, START=1, LENGTH = 0: DONE=1 for one cycle; stay in IDLE; BUSY stays 0; no read.
- ISSUE (one cycle): RD_EN=1, RD_ADDR=idx, BUSY=1. Go to WAIT.
- WAIT (one cycle): RD_EN=0; capture RD_DATA at the end of the cycle into NOTE_SEL; load the counter with NOTE_CYCLES-1. Go to PLAY.
- PLAY (NOTE_CYCLES cycles): NOTE_EN=1; LED = 1 << NOTE_SEL. When the counter reaches 0, load GAP_CYCLES-1 and go to GAP.
- GAP (GAP_CYCLES cycles): NOTE_EN=0; LED=0; NOTE_SEL holds its last value.
  - At counter 0 with idx+1 < len_q: idx increments, go to ISSUE.
  - Otherwise: go to IDLE, BUSY=0, DONE=1 for that single next cycle.
- Per-note period is NOTE_CYCLES + GAP_CYCLES + 2 cycles.
- idx never exceeds len_q-1. With len_q = DEPTH, the last RD_ADDR is DEPTH-1 and no read ever wraps to address 0.
- START while not in IDLE: ignored; LENGTH is not re-sampled.
- ABORT=1 in any state:
  - Next cycle: IDLE, RD_EN=0, NOTE_EN=0, LED=0, BUSY=0, DONE=0.
  - NOTE_SEL holds its value.
  - ABORT has priority over START in the same cycle.
- DONE and START in the same cycle: the new START is accepted normally, since the FSM is already in IDLE.
- Reset asserted mid-playback: immediate return to reset values; no DONE.
- The counter decrements and never underflows; all arithmetic is unsigned. len_q is ADDR_W+1 bits wide so it can hold DEPTH.

Test Plan:
(Run with NOTE_CYCLES=4, GAP_CYCLES=2, DEPTH=16, behavioural store with 1-cycle read latency; START pulsed in cycle 0.)
1. Store = {2,0,3}, LENGTH=3 -> reads are issued in cycles 1, 9 and 17 at addresses 0, 1, 2. NOTE_EN is high in cycles 3-6, 11-14 and 19-22. LED shows 0100, then 0001, then 1000. BUSY covers cycles 1-24. DONE pulses in cycle 25 only.
2. LENGTH=0 -> DONE=1 in cycle 1; RD_EN, BUSY and NOTE_EN never assert.
3. LENGTH=16, then separately LENGTH=20 -> exactly 16 reads at addresses 0..15, 16 notes, DONE in cycle 16*8+1 = 129; no read of address 0 after address 15.
4. LENGTH=3, ABORT at cycle 12 (mid second note) -> cycle 13 has NOTE_EN=0, LED=0, BUSY=0; DONE never asserts. A START at cycle 14 restarts from address 0.
5. LENGTH=2, START re-pulsed at cycles 5 and 10 with LENGTH=7 -> both are ignored; exactly 2 notes play; DONE in cycle 17.
6. RST_N dropped asynchronously mid-GAP -> all outputs are 0 before the next clock edge. After release, the FSM is in IDLE and a fresh START plays from address 0.

Source files
------------

// File: rtl/sequence_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : sequence_player_if
//  Purpose  : Control, sequence-store read port and audio/LED outputs of the
//             Simon sequence player, bundled with player/environment modports.
//  Revision : 1.0 - initial release
// ============================================================================
interface sequence_player_if #(
   parameter int DEPTH = 16
);
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              start;
   logic              abort;
   logic [ADDR_W:0]   length;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_data;
   logic [1:0]        note_sel;
   logic              note_en;
   logic [3:0]        led;
   logic              busy;
   logic              done;

   modport master (
      input  start, abort, length, rd_data,
      output rd_en, rd_addr, note_sel, note_en, led, busy, done
   );

   modport slave (
      output start, abort, length, rd_data,
      input  rd_en, rd_addr, note_sel, note_en, led, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// ============================================================================
//  Module   : sequence_player
//  Purpose  : Plays the stored Simon note sequence: one registered read per
//             note, a timed gated note, then a timed silent gap.
//  Revision : 1.0 - initial release
// ============================================================================
module sequence_player #(
   parameter int DEPTH       = 16,
   parameter int NOTE_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 5_000_000
) (
   input wire                clk,
   input wire                rst_n,
   sequence_player_if.master seq_if
);

   localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_PLAY  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t            state_q,    state_d;
   logic [ADDR_W-1:0] idx_q,      idx_d;
   logic [ADDR_W:0]   len_q,      len_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic              rd_en_q,    rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
   logic [1:0]        note_sel_q, note_sel_d;
   logic              note_en_q,  note_en_d;
   logic [3:0]        led_q,      led_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;

   logic [ADDR_W:0]   w_len_clamp;
   logic [ADDR_W:0]   w_idx_next;

   assign w_len_clamp = (seq_if.length > DEPTH_L) ? DEPTH_L : seq_if.length;
   assign w_idx_next  = {1'b0, idx_q} + (ADDR_W + 1)'(1);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      note_sel_d = note_sel_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (seq_if.start) begin
               if (w_len_clamp != '0) begin
                  len_d   = w_len_clamp;
                  idx_d   = '0;
                  state_d = S_ISSUE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            note_sel_d = seq_if.rd_data;
            cnt_d      = NOTE_LOAD;
            state_d    = S_PLAY;
         end
         S_PLAY: begin
            if (cnt_q == '0) begin
               cnt_d   = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (w_idx_next < len_q) begin
               // idx only advances while another entry remains, so the read
               // address never wraps past the last valid entry.
               idx_d   = idx_q + ADDR_W'(1);
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (seq_if.abort) begin
         state_d    = S_IDLE;
         done_d     = 1'b0;
         note_sel_d = note_sel_q;
      end
   end

   // Outputs are registered versions of what the next state implies.
   always_comb begin
      rd_en_d   = (state_d == S_ISSUE);
      rd_addr_d = (state_d == S_ISSUE) ? idx_d : rd_addr_q;
      note_en_d = (state_d == S_PLAY);
      led_d     = note_en_d ? (4'b0001 << note_sel_d) : 4'b0000;
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         note_sel_q <= '0;
         note_en_q  <= 1'b0;
         led_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         note_sel_q <= note_sel_d;
         note_en_q  <= note_en_d;
         led_q      <= led_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign seq_if.rd_en    = rd_en_q;
   assign seq_if.rd_addr  = rd_addr_q;
   assign seq_if.note_sel = note_sel_q;
   assign seq_if.note_en  = note_en_q;
   assign seq_if.led      = led_q;
   assign seq_if.busy     = busy_q;
   assign seq_if.done     = done_q;

endmodule

`default_nettype wire
